// File: rtl/dm_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped read cache.
// Helpers take a zero-extended 32-bit word address so any ADDR_W/INDEX_W up to 32 bits works.
package dm_cache_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int BLOCK_W     = 128;
  localparam int WORD_W      = BLOCK_W / BLOCK_WORDS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    MEM_REQ = 2'd2
  } state_t;

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int index_w);
    return addr >> (index_w + 2);
  endfunction

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int index_w);
    return (addr >> 2) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [1:0] get_offset(input logic [31:0] addr);
    return addr[1:0];
  endfunction

endpackage

// File: rtl/dm_cache_word_sel.sv
// Combinational 128->32 word mux; one copy serves both the hit and the refill response path.
module dm_cache_word_sel
  import dm_cache_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  input  logic [1:0]         offset,
  output logic [WORD_W-1:0]  word
);

  always_comb begin
    word = block[WORD_W-1:0];
    case (offset)
      2'd0: word = block[WORD_W-1:0];
      2'd1: word = block[2*WORD_W-1:WORD_W];
      2'd2: word = block[3*WORD_W-1:2*WORD_W];
      2'd3: word = block[4*WORD_W-1:3*WORD_W];
      default: word = block[WORD_W-1:0];
    endcase
  end

endmodule

// File: rtl/dm_cache_read_ctrl.sv
// Read-only direct-mapped cache controller: CPU word reads in, 4-word block refills from memory.
// One request in flight at a time; hits answer two cycles after the handshake.
module dm_cache_read_ctrl
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int INDEX_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  input  logic                flush,
  output logic                resp_valid,
  output logic [WORD_W-1:0]   resp_data,
  output logic                resp_hit,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [BLOCK_W-1:0]  mem_block,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    access_count
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [BLOCK_W-1:0]  data_mem [LINES];

  logic [TAG_W-1:0]    cur_tag;
  logic [INDEX_W-1:0]  cur_index;
  logic [1:0]          cur_offset;
  logic                hit;
  logic [BLOCK_W-1:0]  sel_block;
  logic [WORD_W-1:0]   sel_word;
  logic                fill;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cur_tag    = TAG_W'(get_tag(32'(addr_q), INDEX_W));
  assign cur_index  = INDEX_W'(get_index(32'(addr_q), INDEX_W));
  assign cur_offset = get_offset(32'(addr_q));

  assign hit  = valid_q[cur_index] && (tag_mem[cur_index] == cur_tag);
  assign fill = (state == MEM_REQ) && mem_ack;

  // During a refill the word comes straight from the bus, otherwise from the stored line.
  assign sel_block = (state == MEM_REQ) ? mem_block : data_mem[cur_index];

  dm_cache_word_sel u_word_sel (
    .block  (sel_block),
    .offset (cur_offset),
    .word   (sel_word)
  );

  // Held low through reset so every output reads 0 while rst is asserted.
  assign req_ready = rst && (state == IDLE) && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_hit     <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      hit_count    <= '0;
      access_count <= '0;
    end else begin
      // NOTE: default-then-override keeps resp_valid a single-cycle pulse without an extra clear state.
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            addr_q       <= req_addr;
            access_count <= sat_inc(access_count);
            state        <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_data  <= sel_word;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            hit_count  <= sat_inc(hit_count);
            state      <= IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {addr_q[ADDR_W-1:2], 2'b00};
            state    <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_ack) begin
            valid_q[cur_index] <= 1'b1;
            resp_data          <= sel_word;
            resp_valid         <= 1'b1;
            resp_hit           <= 1'b0;
            mem_req            <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (rst && fill) begin
      tag_mem[cur_index]  <= cur_tag;
      data_mem[cur_index] <= mem_block;
    end
  end

endmodule

// File: doc/dm_cache_read_ctrl.md
Name: dm_cache_read_ctrl

Overview:
- Read-only direct-mapped cache controller; the initiator side of the main-memory block-read interface.
- Sits between the CPU word-read port and main memory.
- On a miss it requests a 4-word (128-bit) block, fills the line and returns the addressed word.
- Keeps hit and access statistics counters.

Parameters:
- ADDR_W, 15, word-address width.
- INDEX_W, 10, index bits; lines = 2^INDEX_W; tag width = ADDR_W-INDEX_W-2.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- req_valid  in  1  CPU read request.
- req_addr  in  ADDR_W  CPU word address.
- req_ready  out  1  controller accepts a request this cycle.
- flush  in  1  invalidate all lines.
- resp_valid  out  1  one-cycle pulse: resp_data valid.
- resp_data  out  32  returned word.
- resp_hit  out  1  qualifies resp_valid; 1 = hit, 0 = refill.
- mem_req  out  1  block-read request, level, held until ack.
- mem_addr  out  ADDR_W  block-aligned address {tag,index,2'b00}.
- mem_ack  in  1  memory block valid this cycle.
- mem_block  in  128  word k at bits [32k+31:32k].
- hit_count  out  CNT_W  saturating count of hits.
- access_count  out  CNT_W  saturating count of accepted requests.

Behaviour:
- Address split: offset=addr[1:0], index=addr[INDEX_W+1:2], tag=addr[ADDR_W-1:INDEX_W+2].
- Storage per line: valid bit, tag, 128-bit data, all as registers.
- Reset values: all outputs 0, all valid bits 0, counters 0, state IDLE.
- States are IDLE, LOOKUP, MEM_REQ.
- IDLE:
  - req_ready = 1 when flush==0.
  - If flush: clear every valid bit at this edge and stay in IDLE. flush has priority over req_valid.
  - Else if req_valid: latch req_addr, access_count += 1 (saturating), go to LOOKUP.
- LOOKUP (1 cycle):
  - Hit (valid[index] && tag match): resp_data = word[offset] of the line, resp_valid=1, resp_hit=1 at next edge, hit_count += 1 (saturating), go to IDLE.
  - Miss: go to MEM_REQ.
- Hit latency: handshake at edge N; resp_valid high in cycle N+2; req_ready high again in N+2. Back-to-back hits therefore sustain 1 request per 2 cycles.
- MEM_REQ:
  - mem_req=1 and mem_addr stable until mem_ack is sampled high.
  - On the ack edge: write mem_block, tag and valid=1 into the line.
  - On the same edge: resp_data = mem_block word[offset], resp_valid=1, resp_hit=0, mem_req drops, go to IDLE.
  - Miss latency = 2 cycles + memory wait.
- mem_ack outside MEM_REQ is ignored. flush outside IDLE is ignored; the requester must hold it until req_ready rises.
- Conflict miss: the line is overwritten unconditionally. There is no write-back, as the cache is read-only.
- resp_valid is exactly one cycle; resp_data holds its value until the next response.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-refill: mem_req=0 and the state is IDLE after the reset edge. All lines are invalid. A later mem_ack is ignored.
- req_valid while req_ready==0 is not accepted. The CPU must hold the request.

Decomposition:
- Shared package dm_cache_pkg holds:
  - the state enum (IDLE, LOOKUP, MEM_REQ);
  - BLOCK_WORDS=4;
  - BLOCK_W=128;
  - address-field helper functions get_tag, get_index, get_offset.
- One sub-module, dm_cache_word_sel: combinational 128->32 word mux by offset. It is shared by the hit and refill paths.

Test Plan:
- Cold miss: after reset, read 0x0005. Required:
  - mem_req with mem_addr=0x0004.
  - Ack with mem_block = {32'hD,32'hC,32'hB,32'hA}.
  - resp_data=0x0000000B, resp_hit=0.
  - access_count=1, hit_count=0.
- Hit after fill: read 0x0006, then 0x0004. Required:
  - resp_hit=1 both times, data 0x0C then 0x0A.
  - resp_valid exactly 2 cycles after each handshake.
  - mem_req stays 0.
  - hit_count=2.
- Conflict: after the fill above, read 0x1005 (same index, tag 1). Required:
  - Miss with mem_addr=0x1004.
  - A later read of 0x0005 misses again with mem_addr=0x0004.
- Flush: fill 0x0004, assert flush in IDLE with req_valid=1. Required:
  - The request is not accepted that cycle.
  - The next read of 0x0004 misses.
- Reset mid-refill: rst=0 while mem_req=1. Required:
  - mem_req=0 and counters 0 after the edge.
  - A stray mem_ack produces no resp_valid.
- Saturation: with CNT_W=2, perform 5 hits. Required: hit_count=3, access_count=3.
